// File: rtl/blink_sequencer.sv
// LED pattern sequencer: a prescaled blink timer that advances an 8-bit LED
// register by count-up, count-down, rotate or one-hot ping-pong, driven by a valid/ready command port.
module blink_sequencer #(
  parameter int BASE_DIV = 25000000,
  parameter int DIV_W    = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_arg,
  output logic [7:0] led,
  output logic       tick,
  output logic       running
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;

  localparam logic [1:0] MODE_UP   = 2'd0;
  localparam logic [1:0] MODE_DOWN = 2'd1;
  localparam logic [1:0] MODE_ROT  = 2'd2;

  localparam logic [2:0] OP_LOAD     = 3'd1;
  localparam logic [2:0] OP_SET_RATE = 3'd2;
  localparam logic [2:0] OP_SET_MODE = 3'd3;
  localparam logic [2:0] OP_START    = 3'd4;
  localparam logic [2:0] OP_STOP     = 3'd5;
  localparam logic [2:0] OP_STEP     = 3'd6;
  localparam logic [2:0] OP_CLEAR    = 3'd7;

  localparam logic [DIV_W-1:0] BASE_LAST = DIV_W'(BASE_DIV - 1);

  logic [1:0]       state, state_d;
  logic [1:0]       mode, mode_d;
  logic             dir, dir_d;          // 1 = shifting left in PING mode
  logic [7:0]       rate, rate_d;
  logic [7:0]       rate_cnt, rate_cnt_d;
  logic [DIV_W-1:0] base_cnt, base_cnt_d;
  logic [7:0]       led_d, led_adv;
  logic             dir_adv;
  logic             tick_d;
  logic             accept, base_strobe, one_hot, do_adv, block_adv;

  assign cmd_ready   = ena && (state != ST_STEP);
  assign accept      = cmd_valid && cmd_ready;
  assign running     = (state == ST_RUN);
  assign base_strobe = (base_cnt == BASE_LAST);
  assign one_hot     = (led != 8'd0) && ((led & (led - 8'd1)) == 8'd0);

  // Next LED value for a single advance in the current mode.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    led_adv = led;
    dir_adv = dir;
    case (mode)
      MODE_UP:   led_adv = led + 8'd1;
      MODE_DOWN: led_adv = led - 8'd1;
      MODE_ROT:  led_adv = {led[6:0], led[7]};
      default: begin
        if (!one_hot) begin
          led_adv = 8'h01;
          dir_adv = 1'b1;
        end else if (dir) begin
          if (led == 8'h80) begin
            led_adv = 8'h40;
            dir_adv = 1'b0;
          end else begin
            led_adv = led << 1;
          end
        end else begin
          if (led == 8'h01) begin
            led_adv = 8'h02;
            dir_adv = 1'b1;
          end else begin
            led_adv = led >> 1;
          end
        end
      end
    endcase
  end

  always_comb begin
    state_d    = state;
    mode_d     = mode;
    dir_d      = dir;
    rate_d     = rate;
    rate_cnt_d = rate_cnt;
    base_cnt_d = base_cnt;
    led_d      = led;
    tick_d     = 1'b0;
    do_adv     = 1'b0;
    block_adv  = 1'b0;

    case (state)
      ST_RUN: begin
        if (base_strobe) begin
          base_cnt_d = '0;
          if (rate_cnt == rate) begin
            rate_cnt_d = 8'd0;
            do_adv     = 1'b1;
          end else begin
            rate_cnt_d = rate_cnt + 8'd1;
          end
        end else begin
          base_cnt_d = base_cnt + 1'b1;
        end
      end
      ST_STEP: begin
        do_adv  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        base_cnt_d = '0;
        rate_cnt_d = 8'd0;
      end
    endcase

    // A data-changing command or STOP in the same cycle as a scheduled advance drops the advance.
    if (accept) begin
      case (cmd_op)
        OP_LOAD: begin
          led_d     = cmd_arg;
          block_adv = 1'b1;
        end
        OP_SET_RATE: begin
          rate_d     = cmd_arg;
          base_cnt_d = '0;
          rate_cnt_d = 8'd0;
          block_adv  = 1'b1;
        end
        OP_SET_MODE: begin
          mode_d    = cmd_arg[1:0];
          dir_d     = 1'b1;
          block_adv = 1'b1;
          if (cmd_arg[1:0] == 2'd3) led_d = 8'h01;
        end
        OP_START: begin
          if (state == ST_IDLE) begin
            state_d    = ST_RUN;
            base_cnt_d = '0;
            rate_cnt_d = 8'd0;
          end
        end
        OP_STOP: begin
          if (state == ST_RUN) begin
            state_d    = ST_IDLE;
            base_cnt_d = '0;
            rate_cnt_d = 8'd0;
            block_adv  = 1'b1;
          end
        end
        OP_STEP: begin
          if (state == ST_IDLE) state_d = ST_STEP;
        end
        OP_CLEAR: begin
          led_d      = 8'd0;
          base_cnt_d = '0;
          rate_cnt_d = 8'd0;
          block_adv  = 1'b1;
        end
        default: ;
      endcase
    end

    if (do_adv && !block_adv) begin
      led_d  = led_adv;
      dir_d  = dir_adv;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      state    <= ST_IDLE;
      mode     <= MODE_UP;
      dir      <= 1'b1;
      rate     <= 8'd0;
      rate_cnt <= 8'd0;
      base_cnt <= '0;
      led      <= 8'd0;
      tick     <= 1'b0;
    end else if (ena) begin
      state    <= state_d;
      mode     <= mode_d;
      dir      <= dir_d;
      rate     <= rate_d;
      rate_cnt <= rate_cnt_d;
      base_cnt <= base_cnt_d;
      led      <= led_d;
      tick     <= tick_d;
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_blink_sequencer.sv
// Self-checking bench for blink_sequencer with BASE_DIV=4: a per-cycle vector
// table for command handling plus directed sequences for timing corner cases.
module tb_blink_sequencer;

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_LOAD     = 3'd1;
  localparam logic [2:0] OP_SET_RATE = 3'd2;
  localparam logic [2:0] OP_SET_MODE = 3'd3;
  localparam logic [2:0] OP_START    = 3'd4;
  localparam logic [2:0] OP_STOP     = 3'd5;
  localparam logic [2:0] OP_STEP     = 3'd6;
  localparam logic [2:0] OP_CLEAR    = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_arg;
  logic [7:0] led;
  logic       tick;
  logic       running;

  int errors = 0;
  int checks = 0;

  blink_sequencer #(.BASE_DIV(4), .DIV_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .led       (led),
    .tick      (tick),
    .running   (running)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [2:0] op;
    logic [7:0] arg;
    logic       ena;
    logic [7:0] led;
    logic       tick;
    logic       run;
    logic       rdy;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [2:0] op, input logic [7:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    step();
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_arg   = 8'd0;
  endtask

  // Returns the number of edges until tick is seen, capped at 40.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < 40);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
  endtask

  logic [7:0] ping_exp [15];
  int n;
  int seen;

  initial begin
    rst_n     = 1'b0;
    ena       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_arg   = 8'd0;
    #3;
    check("reset_led", 32'(led), 32'h00);
    check("reset_tick", 32'(tick), 32'h0);
    check("reset_running", 32'(running), 32'h0);
    check("reset_ready", 32'(cmd_ready), 32'h1);
    rst_n = 1'b1;
    step();

    //            valid op           arg    ena  led    tick run  rdy
    vecs[0]  = '{1'b1, OP_LOAD,     8'h0F, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, OP_SET_MODE, 8'h01, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, OP_STEP,     8'h00, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, OP_NOP,      8'h00, 1'b1, 8'h0E, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, OP_NOP,      8'h00, 1'b1, 8'h0E, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, OP_SET_MODE, 8'hFC, 1'b1, 8'h0E, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, OP_STEP,     8'h00, 1'b1, 8'h0E, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, OP_LOAD,     8'h55, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, OP_STOP,     8'h00, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, OP_SET_MODE, 8'h02, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, OP_LOAD,     8'h81, 1'b1, 8'h81, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, OP_STEP,     8'h00, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, OP_NOP,      8'h00, 1'b1, 8'h03, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{1'b1, OP_START,    8'h00, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1};
    vecs[14] = '{1'b1, OP_STOP,     8'h00, 1'b0, 8'h03, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b0, OP_NOP,      8'h00, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1};
    vecs[16] = '{1'b0, OP_NOP,      8'h00, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1};
    vecs[17] = '{1'b0, OP_NOP,      8'h00, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1};
    vecs[18] = '{1'b0, OP_NOP,      8'h00, 1'b1, 8'h06, 1'b1, 1'b1, 1'b1};
    vecs[19] = '{1'b1, OP_STEP,     8'h00, 1'b1, 8'h06, 1'b0, 1'b1, 1'b1};
    vecs[20] = '{1'b1, OP_STOP,     8'h00, 1'b1, 8'h06, 1'b0, 1'b0, 1'b1};
    vecs[21] = '{1'b1, OP_CLEAR,    8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 22; i++) begin
      cmd_valid = vecs[i].valid;
      cmd_op    = vecs[i].op;
      cmd_arg   = vecs[i].arg;
      ena       = vecs[i].ena;
      step();
      check($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].led));
      check($sformatf("vec%0d_tick", i), 32'(tick), 32'(vecs[i].tick));
      check($sformatf("vec%0d_running", i), 32'(running), 32'(vecs[i].run));
      check($sformatf("vec%0d_ready", i), 32'(cmd_ready), 32'(vecs[i].rdy));
    end
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    ena       = 1'b1;

    // UP at rate 0: a tick every 4 clocks, full wrap through FF back to 00.
    do_reset();
    cmd(OP_START, 8'd0);
    for (int k = 1; k <= 256; k++) begin
      wait_tick(n);
      check($sformatf("up_period_%0d", k), 32'(n), 32'd4);
      check($sformatf("up_led_%0d", k), 32'(led), 32'(k[7:0]));
    end

    // Rate 2: period 12; SET_RATE mid-period restarts the period.
    cmd(OP_SET_RATE, 8'd2);
    for (int k = 1; k <= 3; k++) begin
      wait_tick(n);
      check($sformatf("rate2_period_%0d", k), 32'(n), 32'd12);
      check($sformatf("rate2_led_%0d", k), 32'(led), 32'(k));
    end
    repeat (5) step();
    cmd(OP_SET_RATE, 8'd2);
    wait_tick(n);
    check("rate_restart_period", 32'(n), 32'd12);
    check("rate_restart_led", 32'(led), 32'h04);

    // PING: bounce with reversal at both ends.
    ping_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    cmd(OP_STOP, 8'd0);
    cmd(OP_SET_RATE, 8'd0);
    cmd(OP_SET_MODE, 8'h03);
    check("ping_init_led", 32'(led), 32'h01);
    cmd(OP_START, 8'd0);
    for (int k = 0; k < 15; k++) begin
      wait_tick(n);
      check($sformatf("ping_period_%0d", k), 32'(n), 32'd4);
      check($sformatf("ping_led_%0d", k), 32'(led), 32'(ping_exp[k]));
    end
    cmd(OP_STOP, 8'd0);
    cmd(OP_LOAD, 8'h03);
    cmd(OP_STEP, 8'd0);
    step();
    check("ping_nonhot_led", 32'(led), 32'h01);
    check("ping_nonhot_tick", 32'(tick), 32'h1);

    // Collision: LOAD on the scheduled-advance cycle wins and suppresses tick.
    cmd(OP_SET_MODE, 8'h00);
    cmd(OP_LOAD, 8'h10);
    cmd(OP_START, 8'd0);
    wait_tick(n);
    check("coll_pre_led", 32'(led), 32'h11);
    repeat (3) step();
    cmd(OP_LOAD, 8'hAA);
    check("coll_led", 32'(led), 32'hAA);
    check("coll_tick", 32'(tick), 32'h0);
    wait_tick(n);
    check("coll_next_period", 32'(n), 32'd4);
    check("coll_next_led", 32'(led), 32'hAB);

    // ena=0 freezes the prescaler mid-period; resume picks up where it stopped.
    repeat (2) step();
    ena  = 1'b0;
    seen = 0;
    repeat (10) begin
      step();
      if (tick) seen++;
    end
    check("freeze_ticks", 32'(seen), 32'd0);
    check("freeze_led", 32'(led), 32'hAB);
    check("freeze_ready", 32'(cmd_ready), 32'h0);
    ena = 1'b1;
    wait_tick(n);
    check("resume_period", 32'(n), 32'd2);
    check("resume_led", 32'(led), 32'hAC);

    // Asynchronous reset mid-run.
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_led", 32'(led), 32'h00);
    check("arst_running", 32'(running), 32'h0);
    check("arst_tick", 32'(tick), 32'h0);
    check("arst_ready_ena1", 32'(cmd_ready), 32'h1);
    ena = 1'b0;
    #1;
    check("arst_ready_ena0", 32'(cmd_ready), 32'h0);
    ena = 1'b1;
    rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
